// File: rtl/piso_serializer.sv
// piso_serializer: LSB-first parallel-to-serial converter with a post-frame idle gap and flush abort
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic ser_out_q, ser_out_d, ser_valid_q, ser_valid_d, frame_done_q, frame_done_d, in_ready_q, in_ready_d;
  logic last_bit;
  assign last_bit = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    word_d = word_q;
    ser_out_d = 1'b0;
    ser_valid_d = 1'b0;
    frame_done_d = 1'b0;
    if (flush)
      state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          state_d = S_SHIFT;
          word_d = data_in;
          cnt_d = '0;
          ser_out_d = data_in[0];
          ser_valid_d = 1'b1;
        end
        S_SHIFT: if (last_bit) begin
          state_d = GAP == 0 ? S_IDLE : S_GAP;
          gap_d = '0;
        end else begin
          // word_q is shifted so the next bit to send is always at index 1
          word_d = word_q >> 1;
          cnt_d = cnt_q + 1'b1;
          ser_out_d = word_q[1];
          ser_valid_d = 1'b1;
          frame_done_d = cnt_q == CW'(WIDTH - 2);
        end
        S_GAP: begin
          state_d = gap_q == 4'(GAP - 1) ? S_IDLE : S_GAP;
          gap_d = gap_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    in_ready_d = state_d == S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      gap_q <= '0;
      word_q <= '0;
      ser_out_q <= 1'b0;
      ser_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      word_q <= word_d;
      ser_out_q <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      frame_done_q <= frame_done_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready = in_ready_q;
  assign ser_out = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign frame_done = frame_done_q;
endmodule
